prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  instruction memory request strobe.
REQ-006 The block SHALL have port imem_addr  output  32  word-aligned request address.
REQ-007 The block SHALL have port imem_valid  input  1  response strobe, exactly one per request, in order, latency >= 1 cycle.
REQ-008 The block SHALL have port imem_rdata  input  32  response instruction word.
REQ-009 The block SHALL have port redirect  input  1  taken branch/jump from memory stage (PCsrc).
REQ-010 The block SHALL have port redirect_pc  input  32  redirect target (PCplusImm).
REQ-011 The block SHALL have port instr_out  output  32  head instruction to decode.
REQ-012 The block SHALL have port pc_out  output  32  PC of head instruction.
REQ-013 The block SHALL have port out_valid  output  1  head entry valid.
REQ-014 The block SHALL have port out_ready  input  1  decode accepts head this cycle (low = stall).

Function
REQ-015 State SHALL comprise fetch_pc (32b), a DEPTH-entry FIFO of {pc, instr}, count, inflight (requests issued, response pending), drop_cnt (pending responses to discard), and a PC FIFO of inflight request addresses.
REQ-016 imem_req SHALL be high iff !rst && !redirect && (count + inflight) < DEPTH; imem_addr SHALL equal fetch_pc.
REQ-017 On an issue cycle fetch_pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), inflight +1.
REQ-018 A response with drop_cnt == 0 SHALL push {issued pc, imem_rdata} into the FIFO; visible at instr_out no earlier than the next cycle (no bypass).
REQ-019 A response with drop_cnt > 0 SHALL be discarded and decrement drop_cnt; inflight -1 for every response.
REQ-020 out_valid SHALL equal count != 0; instr_out/pc_out SHALL show the head entry; a pop SHALL occur iff out_valid && out_ready && !redirect.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; reservation in REQ-016 guarantees push never overflows; pop on empty is impossible.
REQ-022 On redirect: FIFO emptied (count 0, out_valid 0 next cycle), fetch_pc <= redirect_pc, no issue that cycle, drop_cnt <= inflight after this cycle's response (a response arriving in the redirect cycle is itself discarded).
REQ-023 Redirect SHALL have priority over pop, push and issue in the same cycle; back-to-back redirects SHALL each take the latest redirect_pc and accumulate discards correctly.
REQ-024 Issue SHALL resume the cycle after redirect at redirect_pc, even while drop_cnt > 0.
REQ-025 redirect_pc low two bits SHALL be ignored (forced 0).

Reset
REQ-026 While rst is high: imem_req 0, out_valid 0, count 0, inflight 0, drop_cnt 0, fetch_pc <= RESET_PC; instr_out/pc_out 0.
REQ-027 Reset mid-operation SHALL discard all queued entries; responses arriving during or after reset for pre-reset requests are the memory model's obligation to suppress (bench resets the memory model together with the block).
REQ-028 First cycle after rst falls SHALL issue imem_req with imem_addr == RESET_PC.

Verification
REQ-029 Reset release, 1-cycle memory, out_ready=1 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; pc_out 0x0 valid 2 cycles after first issue.
REQ-030 out_ready=0 held, DEPTH=4 -> exactly 4 requests (0x0..0xC), imem_req then stays 0; out_valid 1, head pc 0x0; raise out_ready -> one new issue per pop.
REQ-031 3-cycle memory latency, redirect to 0x100 with inflight=3 -> those 3 responses dropped, next pc_out is 0x100, then 0x104.
REQ-032 Redirect coinciding with a response and with out_ready=1 -> no pop, response dropped, out_valid 0 next cycle, imem_addr 0x200 (target) the following cycle.
REQ-033 Redirect on two consecutive cycles to 0x40 then 0x80 -> first delivered pc_out is 0x80; no 0x40 entry appears.
REQ-034 Redirect to 0xFFFF_FFF8 -> issued addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: keeps DEPTH fetched words ahead of decode.
// Redirects flush the queue and discard responses still in flight.
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q   [DEPTH];
  logic [31:0]   pcq [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] reqWr;
  logic [AW-1:0] reqRd;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] survivors;
  logic [31:0]   fetchPc;
  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;
  logic          drop;

  // Slots are reserved at issue time, so a push can never overflow.
  assign occ       = {1'b0, count} + {1'b0, inflight};
  assign issue     = !rst && !redirect && (occ < CAP);
  assign drop      = dropCnt != '0;
  assign push      = imem_valid && !drop && !redirect;
  assign out_valid = !rst && (count != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign survivors = inflight - CW'(imem_valid);

  assign imem_req  = issue;
  assign imem_addr = fetchPc;
  assign instr_out = out_valid ? q[head].instr : '0;
  assign pc_out    = out_valid ? q[head].pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      reqWr    <= '0;
      reqRd    <= '0;
      count    <= '0;
      inflight <= '0;
      dropCnt  <= '0;
    end else begin
      if (imem_valid) reqRd <= reqRd + AW'(1);
      if (issue) reqWr <= reqWr + AW'(1);
      if (redirect) begin
        // Everything still outstanding belongs to the old path.
        fetchPc  <= redirect_pc & 32'hFFFF_FFFC;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        inflight <= survivors;
        dropCnt  <= survivors;
      end else begin
        if (issue) fetchPc <= fetchPc + 32'd4;
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count    <= count + CW'(push) - CW'(pop);
        inflight <= inflight + CW'(issue) - CW'(imem_valid);
        if (imem_valid && drop) dropCnt <= dropCnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcq[reqWr] <= fetchPc;
    if (push) q[tail] <= '{pc: pcq[reqRd], instr: imem_rdata};
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: in-order memory model with variable latency
// plus a program-order model of fetch addresses and delivered words.
module tb_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        out_valid;
  logic        out_ready;

  int compared = 0;
  int mismatched = 0;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memq[$];
  logic [31:0] issued[$];
  logic [31:0] popped[$];
  int          cyc = 0;
  int          lat = 1;
  int          jitter = 0;

  logic        sReq, sOv, sRedir, sReady, sRst, sIv;
  logic [31:0] sAddr, sPc, sInstr, sRedirPc;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: present memory response, sample mid-cycle, advance.
  task automatic cycle();
    memReq_t r;
    int d;
    if (rst) begin
      memq.delete();
      imem_valid = 1'b0;
      imem_rdata = '0;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = memData(memq[0].addr);
    end else begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
    @(negedge clk);
    sReq = imem_req; sAddr = imem_addr; sOv = out_valid;
    sPc = pc_out; sInstr = instr_out; sRedir = redirect;
    sRedirPc = redirect_pc; sReady = out_ready; sRst = rst;
    sIv = imem_valid;
    if (rst) begin
      memq.delete();
    end else begin
      if (imem_valid && memq.size() > 0) void'(memq.pop_front());
      if (imem_req) begin
        d = cyc + lat + int'($urandom_range(0, jitter));
        if (memq.size() > 0 && d <= memq[$].due) d = memq[$].due + 1;
        r.addr = imem_addr;
        r.due = d;
        memq.push_back(r);
        issued.push_back(imem_addr);
      end
      if (out_valid && out_ready && !redirect) popped.push_back(pc_out);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    redirect = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    issued.delete();
    popped.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if (sReq !== 1'b0 || sOv !== 1'b0 || sPc !== 32'h0 || sInstr !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_outputs: req=%b valid=%b pc=%h instr=%h want 0/0/0/0",
                 sReq, sOv, sPc, sInstr);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    compared++;
    if (sOv !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_prefill: valid=%b want 1", sOv);
    end
    rst = 1'b1;
    cycle();
    compared++;
    if (sReq !== 1'b0 || sOv !== 1'b0 || sPc !== 32'h0 || sInstr !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_midop: req=%b valid=%b pc=%h instr=%h want 0/0/0/0",
               sReq, sOv, sPc, sInstr);
    end
    rst = 1'b0;
    cycle();
    compared++;
    if (sReq !== 1'b1 || sAddr !== RESET_PC || sOv !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_first_issue: req=%b addr=%h valid=%b want 1/%h/0",
               sReq, sAddr, sOv, RESET_PC);
    end
  endtask

  task automatic test_startup();
    lat = 1; jitter = 0; out_ready = 1'b1;
    doReset();
    cycle();
    compared++;
    if (sReq !== 1'b1 || sAddr !== 32'h0) begin
      mismatched++;
      $display("FAIL startup_issue0: req=%b addr=%h want 1/00000000", sReq, sAddr);
    end
    cycle();
    compared++;
    if (sReq !== 1'b1 || sAddr !== 32'h4 || sOv !== 1'b0) begin
      mismatched++;
      $display("FAIL startup_issue1: req=%b addr=%h valid=%b want 1/00000004/0",
               sReq, sAddr, sOv);
    end
    cycle();
    compared++;
    if (sReq !== 1'b1 || sAddr !== 32'h8) begin
      mismatched++;
      $display("FAIL startup_issue2: req=%b addr=%h want 1/00000008", sReq, sAddr);
    end
    compared++;
    if (sOv !== 1'b1 || sPc !== 32'h0 || sInstr !== memData(32'h0)) begin
      mismatched++;
      $display("FAIL startup_head: valid=%b pc=%h instr=%h want 1/00000000/%h",
               sOv, sPc, sInstr, memData(32'h0));
    end
  endtask

  task automatic test_stall();
    lat = 1; jitter = 0; out_ready = 1'b0;
    doReset();
    for (int i = 0; i < 8; i++) cycle();
    compared++;
    if (issued.size() != 4) begin
      mismatched++;
      $display("FAIL stall_req_count: got %0d want 4", issued.size());
    end else begin
      compared++;
      if (issued[3] !== 32'hC) begin
        mismatched++;
        $display("FAIL stall_last_addr: got %h want 0000000c", issued[3]);
      end
    end
    compared++;
    if (sReq !== 1'b0 || sOv !== 1'b1 || sPc !== 32'h0) begin
      mismatched++;
      $display("FAIL stall_hold: req=%b valid=%b pc=%h want 0/1/00000000",
               sReq, sOv, sPc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    compared++;
    if (issued.size() != popped.size() + DEPTH) begin
      mismatched++;
      $display("FAIL stall_refill: issued %0d want %0d", issued.size(),
               popped.size() + DEPTH);
    end
  endtask

  task automatic test_redirect_latency();
    int n;
    lat = 3; jitter = 0; out_ready = 1'b1;
    doReset();
    for (int i = 0; i < 3; i++) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    popped.delete();
    cycle();
    redirect = 1'b0;
    compared++;
    if (sIv !== 1'b1 || sReq !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_lat_cycle: rsp=%b req=%b want 1/0", sIv, sReq);
    end
    n = 0;
    while (popped.size() < 2 && n < 40) begin
      cycle();
      n++;
    end
    compared++;
    if (popped.size() < 2) begin
      mismatched++;
      $display("FAIL redir_lat_timeout: pops %0d want 2", popped.size());
    end else if (popped[0] !== 32'h100 || popped[1] !== 32'h104) begin
      mismatched++;
      $display("FAIL redir_lat_pcs: got %h,%h want 00000100,00000104",
               popped[0], popped[1]);
    end
  endtask

  task automatic test_redirect_collide();
    lat = 1; jitter = 0; out_ready = 1'b1;
    doReset();
    for (int i = 0; i < 5; i++) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    popped.delete();
    cycle();
    redirect = 1'b0;
    compared++;
    if (sIv !== 1'b1 || sOv !== 1'b1 || sReq !== 1'b0) begin
      mismatched++;
      $display("FAIL collide_setup: rsp=%b valid=%b req=%b want 1/1/0",
               sIv, sOv, sReq);
    end
    cycle();
    compared++;
    if (sOv !== 1'b0 || sReq !== 1'b1 || sAddr !== 32'h200) begin
      mismatched++;
      $display("FAIL collide_after: valid=%b req=%b addr=%h want 0/1/00000200",
               sOv, sReq, sAddr);
    end
    compared++;
    if (popped.size() != 0) begin
      mismatched++;
      $display("FAIL collide_nopop: pops %0d want 0", popped.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    lat = 2; jitter = 1; out_ready = 1'b1;
    doReset();
    for (int i = 0; i < 4; i++) cycle();
    popped.delete();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    n = 0;
    while (popped.size() < 3 && n < 40) begin
      cycle();
      n++;
    end
    bad = 0;
    foreach (popped[i]) if (popped[i] == 32'h40) bad++;
    compared++;
    if (popped.size() < 3 || popped[0] !== 32'h80 || bad != 0) begin
      mismatched++;
      $display("FAIL b2b_redirect: pops=%0d first=%h stale=%0d want >=3/00000080/0",
               popped.size(), popped.size() > 0 ? popped[0] : 32'hx, bad);
    end
  endtask

  task automatic test_wrap();
    int n;
    lat = 1; jitter = 2; out_ready = 1'b1;
    doReset();
    cycle();
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    issued.delete();
    n = 0;
    while (issued.size() < 3 && n < 20) begin
      cycle();
      n++;
    end
    compared++;
    if (issued.size() < 3) begin
      mismatched++;
      $display("FAIL wrap_timeout: issued %0d want 3", issued.size());
    end else if (issued[0] !== 32'hFFFF_FFF8 || issued[1] !== 32'hFFFF_FFFC ||
                 issued[2] !== 32'h0) begin
      mismatched++;
      $display("FAIL wrap_addrs: got %h,%h,%h want fffffff8,fffffffc,00000000",
               issued[0], issued[1], issued[2]);
    end
  endtask

  // Program-order model: fetch addresses and delivered words advance by 4
  // from the reset PC or the latest redirect target.
  task automatic test_random();
    logic [31:0] mPc;
    logic [31:0] mFetch;
    lat = 1; jitter = 3; out_ready = 1'b1;
    doReset();
    mPc = RESET_PC;
    mFetch = RESET_PC;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      cycle();
      if (sRst) begin
        compared++;
        if (sReq !== 1'b0 || sOv !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_reset: req=%b valid=%b want 0/0", sReq, sOv);
        end
        mPc = RESET_PC;
        mFetch = RESET_PC;
      end else if (sRedir) begin
        compared++;
        if (sReq !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_redirect_req: req=%b want 0", sReq);
        end
        mPc = sRedirPc & 32'hFFFF_FFFC;
        mFetch = mPc;
      end else begin
        if (sReq) begin
          compared++;
          if (sAddr !== mFetch) begin
            mismatched++;
            $display("FAIL rand_addr: got %h want %h", sAddr, mFetch);
          end
          compared++;
          if (memq.size() > DEPTH) begin
            mismatched++;
            $display("FAIL rand_outstanding: got %0d want <=%0d", memq.size(), DEPTH);
          end
          mFetch = mFetch + 32'd4;
        end
        if (sOv && sReady) begin
          compared++;
          if (sPc !== mPc || sInstr !== memData(mPc)) begin
            mismatched++;
            $display("FAIL rand_deliver: pc=%h instr=%h want %h/%h",
                     sPc, sInstr, mPc, memData(mPc));
          end
          mPc = mPc + 32'd4;
        end
      end
    end
    rst = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_startup();
    test_stall();
    test_redirect_latency();
    test_redirect_collide();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
